// File: rtl/morse_timing_classifier.sv
// morse_timing_classifier: turns the debounced key level into one-cycle
// dot / dash / letter-gap / word-gap strobes, timed in Morse units of
// TIMER_FINAL_VALUE+1 clock cycles.
module morse_timing_classifier #(
  parameter int unsigned TIMER_FINAL_VALUE = 9_999_999,
  parameter int unsigned DASH_UNITS        = 2,
  parameter int unsigned LG_UNITS          = 3,
  parameter int unsigned WG_UNITS          = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic b,
  output logic dot,
  output logic dash,
  output logic lg,
  output logic wg
);

  localparam int unsigned TW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_LGAP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] t;
  logic [2:0]    u;
  logic [2:0]    u_inc;
  logic          b_q;
  logic          rise;
  logic          wrap;
  logic          reach_lg;
  logic          reach_wg;
  logic          cnt_clr;
  logic          dot_nxt;
  logic          dash_nxt;
  logic          lg_nxt;
  logic          wg_nxt;

  assign rise  = b & ~b_q;
  assign wrap  = (t == TW'(TIMER_FINAL_VALUE));
  assign u_inc = u + 3'd1;
  // Thresholds fire on the edge where u steps onto them, not while it sits there.
  assign reach_lg = wrap && (u != 3'd7) && (u_inc == 3'(LG_UNITS));
  assign reach_wg = wrap && (u != 3'd7) && (u_inc == 3'(WG_UNITS));

  // Key level history; resets high so a key held through reset is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_q <= 1'b1;
    end else begin
      b_q <= b;
    end
  end

  // Tick and saturating unit counters, cleared on entry into PRESS or GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= '0;
      u <= '0;
    end else if (cnt_clr) begin
      t <= '0;
      u <= '0;
    end else if (state != S_IDLE) begin
      if (wrap) begin
        t <= '0;
        if (u != 3'd7) begin
          u <= u_inc;
        end
      end else begin
        t <= t + TW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counter clear and pulse requests; a rise always beats a gap.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    dot_nxt   = 1'b0;
    dash_nxt  = 1'b0;
    lg_nxt    = 1'b0;
    wg_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_PRESS;
          cnt_clr   = 1'b1;
        end
      end
      S_PRESS: begin
        if (!b) begin
          state_nxt = S_GAP;
          cnt_clr   = 1'b1;
          if (u >= 3'(DASH_UNITS)) begin
            dash_nxt = 1'b1;
          end else begin
            dot_nxt = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (rise) begin
          state_nxt = S_PRESS;
          cnt_clr   = 1'b1;
        end else if (reach_lg) begin
          state_nxt = S_LGAP;
          lg_nxt    = 1'b1;
        end
      end
      S_LGAP: begin
        if (rise) begin
          state_nxt = S_PRESS;
          cnt_clr   = 1'b1;
        end else if (reach_wg) begin
          state_nxt = S_IDLE;
          wg_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered one-cycle strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dot  <= 1'b0;
      dash <= 1'b0;
      lg   <= 1'b0;
      wg   <= 1'b0;
    end else begin
      dot  <= dot_nxt;
      dash <= dash_nxt;
      lg   <= lg_nxt;
      wg   <= wg_nxt;
    end
  end

endmodule

// File: tb/tb_morse_timing_classifier.sv
// Directed bench for morse_timing_classifier with a 4-cycle Morse unit.
module tb_morse_timing_classifier;

  localparam int unsigned TFV = 3;
  localparam int K_DOT  = 1;
  localparam int K_DASH = 2;
  localparam int K_LG   = 3;
  localparam int K_WG   = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic b;
  logic dot;
  logic dash;
  logic lg;
  logic wg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int viol   = 0;
  int ev_kind[$];
  int ev_cyc[$];
  logic [3:0] prev_o = 4'b0;

  morse_timing_classifier #(
    .TIMER_FINAL_VALUE(TFV),
    .DASH_UNITS(2),
    .LG_UNITS(3),
    .WG_UNITS(7)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .b(b),
    .dot(dot),
    .dash(dash),
    .lg(lg),
    .wg(wg)
  );

  always #5 clk = ~clk;

  // One clock: drive b, take the edge, log the registered outputs 1 ns later.
  task automatic tick(input logic bv);
    logic [3:0] o;
    b = bv;
    @(posedge clk);
    #1;
    cyc++;
    o = {wg, lg, dash, dot};
    if ($countones(o) > 1) viol++;
    if ((o & prev_o) != 4'b0) viol++;
    prev_o = o;
    if (dot)  begin ev_kind.push_back(K_DOT);  ev_cyc.push_back(cyc); end
    if (dash) begin ev_kind.push_back(K_DASH); ev_cyc.push_back(cyc); end
    if (lg)   begin ev_kind.push_back(K_LG);   ev_cyc.push_back(cyc); end
    if (wg)   begin ev_kind.push_back(K_WG);   ev_cyc.push_back(cyc); end
  endtask

  task automatic hold(input logic bv, input int n);
    repeat (n) tick(bv);
  endtask

  task automatic clr_log();
    ev_kind.delete();
    ev_cyc.delete();
    viol = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dot, dash, lg, wg} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {dot, dash, lg, wg});
    end
    reset_n = 1'b1;
    clr_log();
    hold(1'b1, 20);
    hold(1'b0, 20);
    checks++;
    if (ev_kind.size() !== 0) begin
      errors++;
      $display("FAIL reset_held_key events got %0d want 0", ev_kind.size());
    end
  endtask

  task automatic test_dot();
    int r;
    int ek[3];
    int ec[3];
    clr_log();
    hold(1'b1, 4);
    r = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DOT, K_LG, K_WG};
    ec = '{r, r + 12, r + 28};
    checks++;
    if (ev_kind.size() !== 3) begin
      errors++;
      $display("FAIL dot_count got %0d want 3", ev_kind.size());
    end
    for (int i = 0; i < 3 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL dot_ev%0d got kind %0d @%0d want kind %0d @%0d", i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL dot_pulse_rules got %0d want 0", viol); end
  endtask

  task automatic test_dash(input int n_high, input string nm);
    int r;
    int ek[3];
    int ec[3];
    clr_log();
    hold(1'b1, n_high);
    r = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DASH, K_LG, K_WG};
    ec = '{r, r + 12, r + 28};
    checks++;
    if (ev_kind.size() !== 3) begin
      errors++;
      $display("FAIL %s_count got %0d want 3", nm, ev_kind.size());
    end
    for (int i = 0; i < 3 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL %s_ev%0d got kind %0d @%0d want kind %0d @%0d", nm, i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL %s_pulse_rules got %0d want 0", nm, viol); end
  endtask

  task automatic test_intra_letter();
    int r1;
    int r2;
    int ek[4];
    int ec[4];
    clr_log();
    hold(1'b1, 4);
    r1 = cyc + 1;
    hold(1'b0, 6);
    hold(1'b1, 12);
    r2 = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DOT, K_DASH, K_LG, K_WG};
    ec = '{r1, r2, r2 + 12, r2 + 28};
    checks++;
    if (ev_kind.size() !== 4) begin
      errors++;
      $display("FAIL intra_count got %0d want 4", ev_kind.size());
    end
    for (int i = 0; i < 4 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL intra_ev%0d got kind %0d @%0d want kind %0d @%0d", i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
  endtask

  task automatic test_letter_not_word();
    int r1;
    int r2;
    int ek[5];
    int ec[5];
    clr_log();
    hold(1'b1, 4);
    r1 = cyc + 1;
    hold(1'b0, 16);
    hold(1'b1, 4);
    r2 = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DOT, K_LG, K_DOT, K_LG, K_WG};
    ec = '{r1, r1 + 12, r2, r2 + 12, r2 + 28};
    checks++;
    if (ev_kind.size() !== 5) begin
      errors++;
      $display("FAIL letter_count got %0d want 5", ev_kind.size());
    end
    for (int i = 0; i < 5 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL letter_ev%0d got kind %0d @%0d want kind %0d @%0d", i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL letter_pulse_rules got %0d want 0", viol); end
  endtask

  // Rise lands on the edge where u reaches 3: press wins, no lg.
  task automatic test_collision_lg();
    int r1;
    int r2;
    int ek[4];
    int ec[4];
    clr_log();
    hold(1'b1, 4);
    r1 = cyc + 1;
    hold(1'b0, 12);
    hold(1'b1, 4);
    r2 = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DOT, K_DOT, K_LG, K_WG};
    ec = '{r1, r2, r2 + 12, r2 + 28};
    checks++;
    if (ev_kind.size() !== 4) begin
      errors++;
      $display("FAIL coll_lg_count got %0d want 4", ev_kind.size());
    end
    for (int i = 0; i < 4 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL coll_lg_ev%0d got kind %0d @%0d want kind %0d @%0d", i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
  endtask

  // Rise lands on the edge where u reaches 7 in LGAP: press wins, no wg.
  task automatic test_collision_wg();
    int r1;
    int r2;
    int ek[5];
    int ec[5];
    clr_log();
    hold(1'b1, 4);
    r1 = cyc + 1;
    hold(1'b0, 28);
    hold(1'b1, 4);
    r2 = cyc + 1;
    hold(1'b0, 40);
    ek = '{K_DOT, K_LG, K_DOT, K_LG, K_WG};
    ec = '{r1, r1 + 12, r2, r2 + 12, r2 + 28};
    checks++;
    if (ev_kind.size() !== 5) begin
      errors++;
      $display("FAIL coll_wg_count got %0d want 5", ev_kind.size());
    end
    for (int i = 0; i < 5 && i < ev_kind.size(); i++) begin
      checks++;
      if (ev_kind[i] !== ek[i] || ev_cyc[i] !== ec[i]) begin
        errors++;
        $display("FAIL coll_wg_ev%0d got kind %0d @%0d want kind %0d @%0d", i, ev_kind[i], ev_cyc[i], ek[i], ec[i]);
      end
    end
  endtask

  // Reset in the middle of a press drops it; a key still held is ignored.
  task automatic test_reset_mid_press();
    clr_log();
    hold(1'b1, 6);
    b = 1'b1;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({dot, dash, lg, wg} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b want 0000", {dot, dash, lg, wg});
    end
    hold(1'b1, 2);
    reset_n = 1'b1;
    hold(1'b1, 3);
    hold(1'b0, 40);
    checks++;
    if (ev_kind.size() !== 0) begin
      errors++;
      $display("FAIL midrst_events got %0d want 0", ev_kind.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    b = 1'b0;
    test_reset();
    test_dot();
    test_dash(12, "dash");
    test_dash(40, "long_dash");
    test_intra_letter();
    test_letter_not_word();
    test_collision_lg();
    test_collision_wg();
    test_reset_mid_press();
    test_dot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_timing_classifier.md
# morse_timing_classifier

Converts the debounced Morse key level into one-cycle symbol and gap events: dot, dash, letter gap and word gap. It sits directly upstream of the symbol shift register, digit counter, ROM, FIFO and UART path. Its four outputs drive their shift, enable, reset and write strobes directly. All timing is measured in Morse units of TIMER_FINAL_VALUE+1 clock cycles.

## Interface
- TIMER_FINAL_VALUE, default 9_999_999: terminal count of the unit timer; one unit = TIMER_FINAL_VALUE+1 clk cycles.
- DASH_UNITS, default 2: a press is a dash if the unit count at release is at least this value, otherwise a dot.
- LG_UNITS, default 3: low time after a symbol that produces a letter gap.
- WG_UNITS, default 7: low time after a symbol that produces a word gap; must satisfy LG_UNITS < WG_UNITS ≤ 7.
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- b  in  1  debounced key level, synchronous to clk; 1 = pressed.
- dot  out  1  one-cycle pulse: a dot symbol completed.
- dash  out  1  one-cycle pulse: a dash symbol completed.
- lg  out  1  one-cycle pulse: letter gap, meaning the current letter is finished.
- wg  out  1  one-cycle pulse: word gap, always preceded by lg for the same gap.

## Operation
Datapath:
- Tick counter t: width $clog2(TIMER_FINAL_VALUE+1); counts 0..TIMER_FINAL_VALUE and wraps to 0.
- Unit counter u: 3 bits; increments when t wraps; saturates at 7.
- t and u both clear to 0 on every entry into PRESS or GAP.
- b_q: registered copy of b; reset value 1, so a key held through reset is ignored until it is released.
- rise = b & ~b_q.

States: IDLE, PRESS, GAP, LGAP.
- IDLE: no letter in progress. On rise, go to PRESS.
- PRESS: on b=0, go to GAP. In the same edge, pulse dash if u ≥ DASH_UNITS, else pulse dot.
- GAP: a symbol was sent and its letter is still open.
  - On rise, go to PRESS; the symbol continues the same letter and no gap pulse is issued.
  - Else, when u reaches LG_UNITS, pulse lg and go to LGAP.
- LGAP: lg was issued and the word is still open.
  - On rise, go to PRESS; no wg is issued.
  - Else, when u reaches WG_UNITS, pulse wg and go to IDLE.
- t and u are not cleared on entry to LGAP, so the wg delay is measured from the release.

General rules:
- All outputs are registered.
- At most one of dot, dash, lg, wg is high in any cycle.
- No output ever stays high for two consecutive cycles.
- A long press saturates u at 7 and still classifies as dash on release.
- A gap longer than WG_UNITS produces nothing further.
- A lone press followed by silence always yields the sequence symbol, lg, wg.
- Simultaneous events: if rise occurs on the same edge that u reaches LG_UNITS or WG_UNITS, the press wins. No gap pulse is issued, and the state goes to PRESS.

## Timing
- Reset (asynchronous, reset_n=0): state = IDLE, t = 0, u = 0, b_q = 1, dot = dash = lg = wg = 0.
- Press accepted: the first edge that sees b=1 with b_q=0 enters PRESS.
- Symbol latency: dot or dash is high in the cycle after the first edge that samples b=0 in PRESS (1-cycle latency).
- lg is high in the cycle after u reaches LG_UNITS in GAP, i.e. about LG_UNITS×(TIMER_FINAL_VALUE+1) cycles after release.
- wg is high in the cycle after u reaches WG_UNITS, about WG_UNITS×(TIMER_FINAL_VALUE+1) cycles after release.
- Reset mid-operation: any pulse in flight is dropped, and no symbol or gap is emitted for the interrupted press.
- Downstream may use the pulses directly as strobes; no handshake or back-pressure is provided.

## Test plan
All scenarios use TIMER_FINAL_VALUE=3 (1 unit = 4 cycles) and default thresholds.
- Reset: b=1 during and after reset release for 20 cycles, then b=0 -> no output pulse at all; state stays IDLE.
- Dot then silence: b high 4 cycles then low 40 cycles -> dot for 1 cycle, 1 cycle after release; lg about 12 cycles after release; wg about 28 cycles after release; nothing else.
- Dash: b high 12 cycles then low -> single dash pulse, no dot; then lg and wg as in the previous scenario.
- Intra-letter gap: dot, 6 low cycles, dash -> dot, dash with no lg between; lg only after the final release.
- Letter but not word: dot, 16 low cycles, dot, then silence -> dot, lg, dot, lg, wg; no wg after the first lg.
- Collision: in GAP, assert rise on exactly the edge where u reaches 3 -> no lg, enters PRESS; the following release emits dot.
